// File: rtl/dl_lshift_pkg.sv
// Shared types and helpers for the iterative logical left shifter.
// Holds the FSM state encoding and the per-stage shift distance function.
package dl_lshift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Stage i of the log shifter moves data by 2^i bit positions.
    function automatic int stage_shift(input int idx);
        return 1 << idx;
    endfunction

endpackage

// File: rtl/dl_lshift_stage.sv
// One combinational log-shifter stage, reused every cycle by the iterative top.
// Shifts data_in left by 2^idx when enabled, zero-filling from the LSB.
module dl_lshift_stage
    import dl_lshift_pkg::*;
#(
    parameter int NUM_BITS       = 8,
    parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0]       data_in,
    input  logic                      enable,
    input  logic [NUM_SHIFT_BITS-1:0] idx,
    output logic [NUM_BITS-1:0]       data_out
);

    always_comb begin
        data_out = data_in;
        if (enable) begin
            data_out = data_in << stage_shift(int'(idx));
        end
    end

endmodule

// File: rtl/dl_lshift_iter.sv
// Iterative logical left shifter: applies one log stage per cycle with a fixed
// latency of NUM_SHIFT_BITS cycles, valid/ready handshakes on both sides.
module dl_lshift_iter
    import dl_lshift_pkg::*;
#(
    parameter int NUM_BITS       = 8,
    parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [NUM_BITS-1:0]       in,
    input  logic [NUM_SHIFT_BITS-1:0] shift,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [NUM_BITS-1:0]       out
);

    state_t                    state, state_nxt;
    logic [NUM_BITS-1:0]       data, data_nxt;
    logic [NUM_SHIFT_BITS-1:0] amount, amount_nxt;
    logic [NUM_SHIFT_BITS-1:0] cnt, cnt_nxt;
    logic [NUM_BITS-1:0]       stage_out;
    logic                      cnt_last;

    dl_lshift_stage #(
        .NUM_BITS       (NUM_BITS),
        .NUM_SHIFT_BITS (NUM_SHIFT_BITS)
    ) u_stage (
        .data_in  (data),
        .enable   (amount[cnt]),
        .idx      (cnt),
        .data_out (stage_out)
    );

    assign cnt_last = (int'(cnt) == NUM_SHIFT_BITS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data   <= '0;
            amount <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            data   <= data_nxt;
            amount <= amount_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Every stage is visited regardless of the amount bits so latency is fixed.
    always_comb begin
        state_nxt  = state;
        data_nxt   = data;
        amount_nxt = amount;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (in_val) begin
                    data_nxt   = in;
                    amount_nxt = shift;
                    cnt_nxt    = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                data_nxt = stage_out;
                cnt_nxt  = cnt + 1'b1;
                if (cnt_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_rdy  = (state == IDLE);
    assign out_val = (state == DONE);
    assign out     = data;

endmodule

// File: tb/tb_dl_lshift_iter.sv
// Directed and randomized self-checking bench for dl_lshift_iter (NUM_BITS=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dl_lshift_iter;

    logic       clk;
    logic       rst;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic [2:0] shift;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_data;

    int total;
    int bad;

    dl_lshift_iter #(
        .NUM_BITS       (8),
        .NUM_SHIFT_BITS (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in      (in_data),
        .shift   (shift),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        in_val  = 1'b0;
        in_data = 8'h00;
        shift   = 3'd0;
        out_rdy = 1'b0;
        #12;
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_state: in_rdy=%b out_val=%b out=%h, want 1 0 00",
                     in_rdy, out_val, out_data);
        end
        tick();
        rst = 1'b0;
    endtask

    // Accepts one request with out_rdy high and checks latency, result and release.
    task automatic run_op(input logic [7:0] a, input logic [2:0] s,
                          input logic [7:0] exp, input string name);
        int n;
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_data = a;
        shift   = s;
        tick();
        in_val = 1'b0;
        total++;
        if (in_rdy !== 1'b0 || out_val !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_busy: in_rdy=%b out_val=%b, want 0 0", name, in_rdy, out_val);
        end
        n = 1;
        tick();
        while (out_val !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("[TB] FAIL %s_latency: got %0d edges, want 3", name, n);
        end
        total++;
        if (out_val !== 1'b1 || out_data !== exp) begin
            bad++;
            $display("[TB] FAIL %s_result: out_val=%b out=%h, want 1 %h", name, out_val, out_data, exp);
        end
        tick();
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_release: out_val=%b in_rdy=%b, want 0 1", name, out_val, in_rdy);
        end
    endtask

    task automatic test_basic();
        run_op(8'h81, 3'd1, 8'h02, "basic");
    endtask

    task automatic test_boundaries();
        run_op(8'hFF, 3'd7, 8'h80, "max_shift");
        run_op(8'hA5, 3'd0, 8'hA5, "zero_shift");
        run_op(8'h5A, 3'd3, 8'hD0, "mid_shift");
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_data = 8'h0F;
        shift   = 3'd4;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_val !== 1'b1 || out_data !== 8'hF0 || in_rdy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: out_val=%b out=%h in_rdy=%b, want 1 f0 0",
                         i, out_val, out_data, in_rdy);
            end
            in_val  = 1'b1;
            in_data = 8'h33;
            shift   = 3'd1;
            tick();
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        total++;
        if (out_val !== 1'b1 || out_data !== 8'hF0) begin
            bad++;
            $display("[TB] FAIL bp_final: out_val=%b out=%h, want 1 f0", out_val, out_data);
        end
        tick();
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_complete: out_val=%b in_rdy=%b, want 0 1", out_val, in_rdy);
        end
        tick();
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_no_accept: in_rdy=%b out_val=%b, want 1 0", in_rdy, out_val);
        end
    endtask

    task automatic test_isolation();
        int n;
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_data = 8'h3C;
        shift   = 3'd2;
        tick();
        n = 0;
        while (out_val !== 1'b1 && n < 20) begin
            in_data = 8'($urandom);
            shift   = 3'($urandom);
            tick();
            n++;
        end
        in_val = 1'b0;
        total++;
        if (out_val !== 1'b1 || out_data !== 8'hF0) begin
            bad++;
            $display("[TB] FAIL isolation: out_val=%b out=%h, want 1 f0", out_val, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_data = 8'hC3;
        shift   = 3'd5;
        tick();
        in_val = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (out_val !== 1'b0 || out_data !== 8'h00 || in_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reset: out_val=%b out=%h in_rdy=%b, want 0 00 1",
                     out_val, out_data, in_rdy);
        end
        tick();
        rst = 1'b0;
        run_op(8'h01, 3'd3, 8'h08, "after_reset");
    endtask

    // Random back-to-back traffic against an in-order scoreboard.
    task automatic test_back_to_back();
        logic [7:0] sb[$];
        logic [7:0] exp;
        int         accepted;
        int         completed;
        int         drain;
        accepted  = 0;
        completed = 0;
        for (int c = 0; c < 400; c++) begin
            in_val  = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            shift   = 3'($urandom);
            out_rdy = ($urandom_range(0, 1) == 1);
            if (in_val && in_rdy) begin
                exp = in_data << shift;
                sb.push_back(exp);
                accepted++;
            end
            if (out_val && out_rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL soak_extra: out=%h with empty scoreboard", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        bad++;
                        $display("[TB] FAIL soak_txn%0d: out=%h, want %h", completed, out_data, exp);
                    end
                end
                completed++;
            end
            tick();
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        drain   = 0;
        while (sb.size() != 0 && drain < 20) begin
            if (out_val) begin
                total++;
                exp = sb.pop_front();
                if (out_data !== exp) begin
                    bad++;
                    $display("[TB] FAIL soak_drain%0d: out=%h, want %h", completed, out_data, exp);
                end
                completed++;
            end
            tick();
            drain++;
        end
        total++;
        if (completed != accepted || accepted < 20) begin
            bad++;
            $display("[TB] FAIL soak_count: completed=%0d accepted=%0d (need equal, >=20)",
                     completed, accepted);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_isolation();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dl_lshift_iter.md
# dl_lshift_iter

Iterative logical left shifter with valid/ready handshakes on both sides. It is the left-shifting counterpart to the single-cycle arithmetic right shifter in the design library, built for area-constrained datapaths. It applies one log-stage per cycle, shifting by 2^i when shift bit i is set. The result appears after a fixed latency of NUM_SHIFT_BITS cycles, so execute-stage wrappers in the RISC-V core can hold it under backpressure.

## Interface
- NUM_BITS, 8, data width; power of two, ≥2
- NUM_SHIFT_BITS, $clog2(NUM_BITS), shift-amount width and stage count
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_val  in  1  request valid
- in_rdy  out  1  block can accept a request
- in  in  NUM_BITS  operand
- shift  in  NUM_SHIFT_BITS  shift amount, unsigned
- out_val  out  1  result valid
- out_rdy  in  1  consumer accepts result
- out  out  NUM_BITS  shifted result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_rdy=1.
  - On in_val: capture in→data register, shift→amount register, clear stage counter cnt to 0, go to BUSY.
- BUSY:
  - in_rdy=0, out_val=0.
  - Each cycle: data ← amount[cnt] ? data << (1<<cnt) : data. Zeros fill from the LSB. Bits shifted past MSB are discarded.
  - cnt increments. When cnt==NUM_SHIFT_BITS-1, the stage is applied and the block goes to DONE.
- DONE:
  - out_val=1, out=data. Both are held stable while out_rdy=0.
  - On out_rdy: go to IDLE.
- Fixed latency: every stage is visited even when amount bits are 0. shift=0 takes the same latency as shift=NUM_SHIFT_BITS-1.
- in_val and operand changes are ignored outside IDLE. Operands are sampled only at acceptance.
- Arithmetic: shift amount is unsigned and always <NUM_BITS. out equals (in << shift) truncated to NUM_BITS.

## Timing
- Reset (async assert, any state): state=IDLE, data=0, amount=0, cnt=0, in_rdy=1, out_val=0, out=0. An operation in flight is discarded.
- Reset deassertion: the first acceptance can occur on the first rising edge after deassertion.
- Acceptance on edge E0. Stages are applied on edges E1..E_NUM_SHIFT_BITS.
  - out_val rises after edge E_NUM_SHIFT_BITS; for NUM_BITS=8, that is 3 edges after acceptance.
- Result handshake completes on the edge where out_val && out_rdy. in_rdy is 1 in the following cycle.
  - No same-cycle bypass from DONE to accept.
  - Minimum request-to-request spacing is NUM_SHIFT_BITS+2 cycles.
- out_rdy held high before the result: the result leaves after exactly one DONE cycle.
- out_rdy held low indefinitely: the block stays in DONE with out constant.
- All outputs are registered or decoded from registered state. There is no combinational path from in_val or out_rdy to any output.

## Structure
- Package dl_lshift_pkg:
  - state enum (IDLE, BUSY, DONE).
  - Helper function computing the stage shift 1<<cnt, parameterized via a NUM_BITS-independent int argument.
- Sub-module dl_lshift_stage:
  - Combinational single stage: data_in, enable, stage index → data_in << (1<<idx) when enabled.
  - Instantiated once and fed by cnt; not unrolled.
- The top module holds the FSM, counter, and operand registers.

## Test plan
- Basic, NUM_BITS=8: reset, then in=8'h81, shift=1, out_rdy=1 → out_val after 3 edges, out=8'h02, then in_rdy=1 the next cycle.
- Maximum shift: in=8'hFF, shift=7 → out=8'h80. Zero shift: in=8'hA5, shift=0 → out=8'hA5 with the same 3-cycle latency.
- Backpressure: in=8'h0F, shift=4, out_rdy=0 for 5 cycles after out_val.
  - out_val and out=8'hF0 stay stable throughout.
  - A new in_val driven during that time is not accepted.
  - Completion occurs on the edge where out_rdy=1.
- Operand isolation: change in/shift to random values during BUSY → result reflects only the values captured at acceptance.
- Reset mid-operation: assert rst one cycle after acceptance → immediately out_val=0, out=0, in_rdy=1. A request after deassertion (in=8'h01, shift=3) completes normally with out=8'h08.
- Random soak: back-to-back random in/shift with random out_rdy → scoreboard (in<<shift)&8'hFF matches every completed transaction, in order, none dropped.
